// File: rtl/euler_step_engine.sv
// euler_step_engine: one explicit Euler step x' = x + h*(A*x + B*u) over RAM-resident matrices.
// Build option EULER_SATURATE_EN: clamp out-of-range results and flag OVF; otherwise results wrap.
module euler_step_engine #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 8,
  parameter int DIM_WIDTH     = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         START,
  input  logic [DIM_WIDTH-1:0]         N_DIM,
  input  logic [DIM_WIDTH-1:0]         M_DIM,
  input  logic signed [DATA_WIDTH-1:0] H_VAL,
  input  logic [ADDRESS_WIDTH-1:0]     A_BASE,
  input  logic [ADDRESS_WIDTH-1:0]     B_BASE,
  input  logic [ADDRESS_WIDTH-1:0]     X_BASE,
  input  logic [ADDRESS_WIDTH-1:0]     U_BASE,
  input  logic [ADDRESS_WIDTH-1:0]     XNEW_BASE,
  output logic [ADDRESS_WIDTH-1:0]     RD_ADDR1,
  output logic [ADDRESS_WIDTH-1:0]     RD_ADDR2,
  input  logic signed [DATA_WIDTH-1:0] RD_DATA1,
  input  logic signed [DATA_WIDTH-1:0] RD_DATA2,
  output logic                         WR_EN,
  output logic [ADDRESS_WIDTH-1:0]     WR_ADDR,
  output logic signed [DATA_WIDTH-1:0] WR_DATA,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         OVF
);
  localparam int AW   = ADDRESS_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int ACCW = 2*DW+8;
  localparam int RW   = ACCW+DW+1;
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [DIM_WIDTH-1:0] D1 = DIM_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, MAC_AX, MAC_BU, READ_X, WRITE, FINISH} state_t;
  state_t state_q, state_d;
  logic [DIM_WIDTH-1:0] n_q, n_d, m_q, m_d, cnt_q, cnt_d, row_q, row_d;
  logic signed [DW-1:0] h_q, h_d, res;
  logic [AW-1:0] a_q, a_d, b_q, b_d, x_q, x_d, u_q, u_d;
  logic [AW-1:0] xi_q, xi_d, wr_q, wr_d, xb_q, xb_d, ub_q, ub_d;
  logic signed [ACCW-1:0] acc_q, acc_d, acc_sh;
  logic signed [2*DW-1:0] prod;
  logic signed [RW-2:0] scaled;
  logic signed [RW-1:0] sum;
`ifdef EULER_SATURATE_EN
  logic ovr, ovf_q, ovf_d;
`endif
  // Datapath: product of the pair read last cycle, and the row result from the accumulator and X[i].
  always_comb begin
    prod   = (2*DW)'(RD_DATA1) * (2*DW)'(RD_DATA2);
    acc_sh = acc_q >>> FRAC_BITS;
    scaled = ((RW-1)'(acc_sh) * (RW-1)'(h_q)) >>> FRAC_BITS;
    sum    = RW'(scaled) + RW'(RD_DATA1);
`ifdef EULER_SATURATE_EN
    ovr = ~(&sum[RW-1:DW-1]) & (|sum[RW-1:DW-1]);
    res = ovr ? {sum[RW-1], {(DW-1){~sum[RW-1]}}} : sum[DW-1:0];
`else
    res = DW'(sum);
`endif
  end
  // Next-state logic: sequencing, pointer counters and accumulation.
  always_comb begin
    state_d = state_q;
    n_d = n_q; m_d = m_q; h_d = h_q; cnt_d = cnt_q; row_d = row_q;
    a_d = a_q; b_d = b_q; x_d = x_q; u_d = u_q;
    xi_d = xi_q; wr_d = wr_q; xb_d = xb_q; ub_d = ub_q;
    acc_d = acc_q;
`ifdef EULER_SATURATE_EN
    ovf_d = ovf_q;
`endif
    case (state_q)
      IDLE: if (START) begin
        state_d = (N_DIM == '0) ? FINISH : MAC_AX;
        n_d = N_DIM; m_d = M_DIM; h_d = H_VAL; cnt_d = '0; row_d = '0;
        a_d = A_BASE; b_d = B_BASE; x_d = X_BASE; u_d = U_BASE;
        xi_d = X_BASE; wr_d = XNEW_BASE; xb_d = X_BASE; ub_d = U_BASE;
`ifdef EULER_SATURATE_EN
        ovf_d = 1'b0;
`endif
      end
      MAC_AX: begin
        acc_d = (cnt_q == '0) ? '0 : acc_q + ACCW'(prod);
        a_d = a_q + A1; x_d = x_q + A1; cnt_d = cnt_q + D1;
        if (cnt_q == n_q - D1) begin
          cnt_d = '0;
          state_d = (m_q == '0) ? READ_X : MAC_BU;
        end
      end
      MAC_BU: begin
        acc_d = acc_q + ACCW'(prod);
        b_d = b_q + A1; u_d = u_q + A1; cnt_d = cnt_q + D1;
        if (cnt_q == m_q - D1) begin
          cnt_d = '0;
          state_d = READ_X;
        end
      end
      READ_X: begin
        acc_d = acc_q + ACCW'(prod);
        state_d = WRITE;
      end
      WRITE: begin
        xi_d = xi_q + A1; wr_d = wr_q + A1; x_d = xb_q; u_d = ub_q; row_d = row_q + D1;
        state_d = (row_q == n_q - D1) ? FINISH : MAC_AX;
`ifdef EULER_SATURATE_EN
        ovf_d = ovf_q | ovr;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  // State and counter registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      n_q <= '0; m_q <= '0; h_q <= '0; cnt_q <= '0; row_q <= '0;
      a_q <= '0; b_q <= '0; x_q <= '0; u_q <= '0;
      xi_q <= '0; wr_q <= '0; xb_q <= '0; ub_q <= '0;
      acc_q <= '0;
`ifdef EULER_SATURATE_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q <= n_d; m_q <= m_d; h_q <= h_d; cnt_q <= cnt_d; row_q <= row_d;
      a_q <= a_d; b_q <= b_d; x_q <= x_d; u_q <= u_d;
      xi_q <= xi_d; wr_q <= wr_d; xb_q <= xb_d; ub_q <= ub_d;
      acc_q <= acc_d;
`ifdef EULER_SATURATE_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  // Outputs decode from state so reset clears them immediately.
  always_comb begin
    BUSY     = state_q != IDLE;
    DONE     = state_q == FINISH;
    WR_EN    = state_q == WRITE;
    WR_ADDR  = WR_EN ? wr_q : '0;
    WR_DATA  = WR_EN ? res : '0;
    RD_ADDR1 = (state_q == MAC_AX) ? a_q : (state_q == MAC_BU) ? b_q : (state_q == READ_X) ? xi_q : '0;
    RD_ADDR2 = (state_q == MAC_AX) ? x_q : (state_q == MAC_BU) ? u_q : '0;
`ifdef EULER_SATURATE_EN
    OVF = ovf_q;
`else
    OVF = 1'b0;
`endif
  end
endmodule

// File: tb/tb_euler_step_engine.sv
// tb_euler_step_engine: table-driven directed checks of euler_step_engine with a RAM model.
module tb_euler_step_engine;
`ifdef EULER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct packed {
    int n;
    int m;
    logic [15:0] h;
    logic [0:3][15:0] a;
    logic [0:3][15:0] b;
    logic [0:1][15:0] x;
    logic [0:1][15:0] u;
    logic [0:1][15:0] e;
    int lat;
    bit ovf;
  } vec_t;
  logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
  logic [7:0] N_DIM = '0, M_DIM = '0;
  logic signed [15:0] H_VAL = '0;
  logic [12:0] RD_ADDR1, RD_ADDR2, WR_ADDR;
  logic signed [15:0] RD_DATA1, RD_DATA2, WR_DATA;
  logic WR_EN, BUSY, DONE, OVF;
  logic [15:0] mem [0:8191];
  logic [12:0] wa [$];
  logic signed [15:0] wd [$];
  vec_t vt [8];
  int n_chk = 0, n_fail = 0;

  euler_step_engine dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .N_DIM(N_DIM), .M_DIM(M_DIM), .H_VAL(H_VAL),
    .A_BASE(13'd100), .B_BASE(13'd200), .X_BASE(13'd300), .U_BASE(13'd400), .XNEW_BASE(13'd500),
    .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2), .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    RD_DATA1 <= mem[RD_ADDR1];
    RD_DATA2 <= mem[RD_ADDR2];
  end

  always @(negedge CLK) if (WR_EN === 1'b1) begin
    wa.push_back(WR_ADDR);
    wd.push_back(WR_DATA);
  end

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int n, int m, logic [15:0] h, logic [0:3][15:0] a, logic [0:3][15:0] b,
                              logic [0:1][15:0] x, logic [0:1][15:0] u, logic [0:1][15:0] e, int lat, bit ovf);
    vec_t v;
    v.n = n; v.m = m; v.h = h; v.a = a; v.b = b; v.x = x; v.u = u; v.e = e; v.lat = lat; v.ovf = ovf;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int r = 0; r < v.n; r++) begin
      for (int c = 0; c < v.n; c++) mem[100+r*v.n+c] = v.a[r*v.n+c];
      for (int k = 0; k < v.m; k++) mem[200+r*v.m+k] = v.b[r*v.m+k];
      mem[300+r] = v.x[r];
    end
    for (int k = 0; k < v.m; k++) mem[400+k] = v.u[k];
    N_DIM = 8'(v.n);
    M_DIM = 8'(v.m);
    H_VAL = v.h;
    wa.delete();
    wd.delete();
  endtask

  task automatic run_vec(input vec_t v, input bit dbl, input string tag);
    int cyc;
    load(v);
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    N_DIM = 8'd7;
    H_VAL = 16'sd0;
    cyc = 1;
    check({tag, "_busy_first"}, 32'(BUSY), 1);
    while (DONE !== 1'b1 && cyc < 200) begin
      START = dbl && cyc == 2;
      @(negedge CLK);
      START = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, cyc, v.lat);
    check({tag, "_busy_at_done"}, 32'(BUSY), 1);
    check({tag, "_ovf"}, 32'(OVF), 32'(v.ovf));
    check({tag, "_nwrites"}, wa.size(), v.n);
    for (int r = 0; r < v.n && r < wa.size(); r++) begin
      check($sformatf("%s_addr%0d", tag, r), 32'(wa[r]), 500 + r);
      check($sformatf("%s_data%0d", tag, r), 32'(wd[r]), 32'($signed(v.e[r])));
    end
    @(negedge CLK);
    check({tag, "_idle_after"}, 32'({BUSY, DONE, WR_EN}), 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    vt[0] = mk(1, 1, 16'sd128, {16'sd256, 48'd0}, 64'd0, {16'sd512, 16'sd0}, 32'd0, {16'sd768, 16'sd0}, 5, 1'b0);
    vt[1] = mk(2, 0, 16'sd256, {16'sd256, 16'sd0, 16'sd0, 16'sd256}, 64'd0, {16'sd256, -16'sd512}, 32'd0,
               {16'sd512, -16'sd1024}, 9, 1'b0);
    vt[2] = mk(1, 1, 16'sd256, {16'sd256, 48'd0}, 64'd0, {16'h7F00, 16'd0}, 32'd0,
               {SAT ? 16'h7FFF : 16'hFE00, 16'd0}, 5, SAT);
    vt[3] = mk(2, 2, 16'sd256, {16'sd256, 16'sd256, 16'sd0, 16'sd128}, {16'sd256, 16'sd0, 16'sd0, 16'sd256},
               {16'sd256, 16'sd512}, {-16'sd256, 16'sd512}, {16'sd768, 16'sd1280}, 13, 1'b0);
    vt[4] = mk(1, 0, 16'sd128, {16'sd1, 48'd0}, 64'd0, {-16'sd3, 16'sd0}, 32'd0, {-16'sd4, 16'sd0}, 4, 1'b0);
    vt[5] = mk(1, 2, 16'sd64, {16'sd512, 48'd0}, {16'sd256, -16'sd256, 32'd0}, {-16'sd256, 16'sd0},
               {16'sd1024, 16'sd256}, {-16'sd192, 16'sd0}, 6, 1'b0);
    vt[6] = mk(1, 0, 16'sd256, {16'sd256, 48'd0}, 64'd0, {-16'sd32512, 16'sd0}, 32'd0,
               {SAT ? 16'h8000 : 16'h0200, 16'd0}, 4, SAT);
    vt[7] = mk(0, 2, 16'sd256, 64'd0, 64'd0, 32'd0, 32'd0, 32'd0, 1, 1'b0);

    @(negedge CLK);
    check("rst_busy_done_wren_ovf", 32'({BUSY, DONE, WR_EN, OVF}), 0);
    check("rst_rd_addr", 32'({RD_ADDR1, RD_ADDR2}), 0);
    check("rst_wr_addr_data", 32'({WR_ADDR, WR_DATA}), 0);
    @(negedge CLK) RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));

    run_vec(vt[0], 1'b1, "start_while_busy");

    load(vt[3]);
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    cyc = 1;
    while (cyc < 9) begin
      @(negedge CLK);
      cyc++;
    end
    check("midrst_busy_before", 32'(BUSY), 1);
    check("midrst_writes_before", wa.size(), 1);
    RST_N = 1'b0;
    #1;
    check("midrst_wren_busy_done", 32'({WR_EN, BUSY, DONE}), 0);
    check("midrst_rd_addr", 32'({RD_ADDR1, RD_ADDR2}), 0);
    repeat (3) @(negedge CLK);
    check("midrst_no_more_writes", wa.size(), 1);
    RST_N = 1'b1;
    @(negedge CLK);
    run_vec(vt[3], 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
